fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, byte address loaded into the PC on reset.
REQ-002 Parameter IMEM_WORDS, default 32, number of 32-bit words in the instruction memory.
REQ-003 clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  hazard stall; when high, PC and IF/ID register hold.
REQ-006 redirect  input  1  branch/jump taken; PC loads redirect_target and IF/ID is flushed.
REQ-007 redirect_target  input  32  new fetch byte address.
REQ-008 imem_addr  output  5  word address driven to the combinational instruction memory, equal to pc[6:2].
REQ-009 imem_inst  input  32  instruction word returned by memory in the same cycle.
REQ-010 ifid_inst  output  32  registered instruction for decode.
REQ-011 ifid_pc4  output  32  registered PC+4 of that instruction.
REQ-012 ifid_valid  output  1  high when ifid_inst is a real instruction; low means bubble.
REQ-013 pc  output  32  current fetch PC.
REQ-014 halted  output  1  high while the FSM is in HALT.

Function
REQ-015 The FSM SHALL have three states: BOOT, RUN and HALT.
REQ-016 BOOT SHALL last exactly one cycle after reset release, then go to RUN, with no fetch captured in that cycle.
REQ-017 The per-edge update priority SHALL be: reset > redirect > stall > sequential advance.
REQ-018 In RUN with no redirect and no stall: pc <= pc+4; ifid_inst <= imem_inst; ifid_pc4 <= pc+4; ifid_valid <= 1.
REQ-019 On redirect, in any state other than BOOT: pc <= {redirect_target[31:2],2'b00}; ifid_inst <= 0; ifid_valid <= 0; state <= RUN.
REQ-020 Redirect SHALL override a simultaneous stall.
REQ-021 When stall is high without redirect, pc, ifid_inst, ifid_pc4, ifid_valid and the state SHALL all hold.
REQ-022 A fetch PC at or beyond IMEM_WORDS*4 (pc >= 32'h80 by default) SHALL be out of range.
REQ-023 For an out-of-range PC in RUN, the block SHALL insert a bubble (ifid_valid <= 0), hold pc, and enter HALT instead of wrapping imem_addr.
REQ-024 In HALT, pc SHALL hold and ifid_valid SHALL be 0.
REQ-025 Redirect is the only exit from HALT.
REQ-026 ifid_inst SHALL read 0 (NOP) whenever ifid_valid is 0.
REQ-027 All PC arithmetic is modulo 2^32, and bits [1:0] of pc SHALL always be 0.
REQ-028 imem_addr is combinational from pc and SHALL add zero cycles of latency.
REQ-029 Fetch-to-decode latency SHALL be exactly 1 cycle.

Reset
REQ-030 While rst_n is low, asynchronously: pc = RESET_PC; ifid_inst = 0; ifid_pc4 = 0; ifid_valid = 0; halted = 0; state = BOOT.
REQ-031 Reset asserted mid-operation, including during stall, redirect or HALT, SHALL discard all in-flight state.
REQ-032 After rst_n deasserts, the first valid IF/ID capture SHALL occur on the second rising edge.

Structure
REQ-033 A shared package SHALL hold: the FSM state enum {BOOT, RUN, HALT}, the NOP constant 32'h00000000, and the instruction/address width constants (32, 5).
REQ-034 The block SHALL contain exactly one sub-module, pc_reg: the PC register with async reset, hold enable and load.
REQ-035 The IF/ID register and the FSM SHALL reside in fetch_stage.

Verification
REQ-036 Reset release with a memory model holding 20020005, 20070003 at words 0 and 1 -> edge 1: ifid_valid = 0 (BOOT); edge 2: ifid_inst = 20020005, ifid_pc4 = 4; edge 3: ifid_inst = 20070003, ifid_pc4 = 8.
REQ-037 Stall held 3 cycles at pc = 0x0C -> pc, ifid_inst and ifid_valid unchanged for 3 edges, then pc = 0x10 on release.
REQ-038 redirect = 1 with target 0x3E and stall = 1 in the same cycle -> next pc = 0x3C, ifid_valid = 0, imem_addr = 15.
REQ-039 Sequential run reaching pc = 0x80 -> halted = 1, pc stays 0x80, ifid_valid = 0; a later redirect to 0x00 -> RUN, and the next edge captures word 0.
REQ-040 rst_n pulsed low mid-cycle while in HALT -> outputs immediately at reset values and state = BOOT without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;
  localparam int          XLEN    = 32;
  localparam int          IADDR_W = 5;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: async reset, load beats sequential advance, en gates advance.
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            load,
  input  logic [XLEN-1:0] load_addr,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc <= align_word(RESET_PC);
    else if (load) pc <= align_word(load_addr);
    else if (en)   pc <= pc + 32'd4;
  end
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, boot/run/halt sequencing and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_target,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_inst,
  output logic [XLEN-1:0]    ifid_inst,
  output logic [XLEN-1:0]    ifid_pc4,
  output logic               ifid_valid,
  output logic [XLEN-1:0]    pc,
  output logic               halted
);
  localparam logic [XLEN-1:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  fetch_state_e state_q, state_d;
  logic         pc_load, pc_inc, capture, flush;
  logic         out_of_range;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4     = pc + 32'd4;
  assign out_of_range = (pc >= PC_LIMIT);
  assign imem_addr    = pc[IADDR_W+1:2];
  assign halted       = (state_q == HALT);

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pc_inc),
    .load      (pc_load),
    .load_addr (redirect_target),
    .pc        (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Redirect is ignored in BOOT; otherwise redirect > stall > advance.
  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    capture = 1'b0;
    flush   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect) begin
          pc_load = 1'b1;
          flush   = 1'b1;
        end else if (!stall) begin
          if (out_of_range) begin
            flush   = 1'b1;
            state_d = HALT;
          end else begin
            pc_inc  = 1'b1;
            capture = 1'b1;
          end
        end
      end
      HALT: begin
        if (redirect) begin
          pc_load = 1'b1;
          flush   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // A flush keeps ifid_pc4 so only inst/valid carry the bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_inst  <= NOP;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (capture) begin
      ifid_inst  <= imem_inst;
      ifid_pc4   <= pc_plus4;
      ifid_valid <= 1'b1;
    end else if (flush) begin
      ifid_inst  <= NOP;
      ifid_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage with an expected-value scoreboard queue.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect;
  logic [31:0] redirect_target;
  logic [4:0]  imem_addr;
  logic [31:0] imem_inst, ifid_inst, ifid_pc4, pc;
  logic        ifid_valid, halted;
  logic [31:0] mem [32];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        halted;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  assign imem_inst = mem[imem_addr];

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_inst       (imem_inst),
    .ifid_inst       (ifid_inst),
    .ifid_pc4        (ifid_pc4),
    .ifid_valid      (ifid_valid),
    .pc              (pc),
    .halted          (halted)
  );

  function automatic logic [31:0] mw(input int i);
    if (i == 0) return 32'h2002_0005;
    if (i == 1) return 32'h2007_0003;
    return 32'hA000_0000 | 32'(i);
  endfunction

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                              input logic [31:0] p, input logic v, input logic [31:0] in,
                              input logic [31:0] p4, input logic h);
    vec_t x;
    x.stall = s; x.redir = r; x.tgt = t;
    x.pc = p; x.valid = v; x.inst = in; x.pc4 = p4; x.halted = h;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    chk({tag, ".pc"},        pc, e.pc);
    chk({tag, ".valid"},     32'(ifid_valid), 32'(e.valid));
    chk({tag, ".inst"},      ifid_inst, e.inst);
    chk({tag, ".pc4"},       ifid_pc4, e.pc4);
    chk({tag, ".halted"},    32'(halted), 32'(e.halted));
    chk({tag, ".imem_addr"}, 32'(imem_addr), 32'(e.pc[6:2]));
  endtask

  // Entered at a negedge; drives, pushes expectation, samples 1ns after posedge.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    stall = v.stall; redirect = v.redir; redirect_target = v.tgt;
    sb.push_back(v);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check_outs($sformatf("v%0d", idx), e);
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t rst_exp;
    for (int i = 0; i < 32; i++) mem[i] = mw(i);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    rst_exp = mk(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1 check_outs("reset", rst_exp);

    // Boot, sequential fetch, stall at 0x0C, redirect+stall, run to halt, recover, wrap.
    tbl.push_back(mk(0, 0, 0,            32'h00, 0, 32'h0,  32'h00, 0));
    tbl.push_back(mk(0, 0, 0,            32'h04, 1, mw(0),  32'h04, 0));
    tbl.push_back(mk(0, 0, 0,            32'h08, 1, mw(1),  32'h08, 0));
    tbl.push_back(mk(0, 0, 0,            32'h0C, 1, mw(2),  32'h0C, 0));
    tbl.push_back(mk(1, 0, 0,            32'h0C, 1, mw(2),  32'h0C, 0));
    tbl.push_back(mk(1, 0, 0,            32'h0C, 1, mw(2),  32'h0C, 0));
    tbl.push_back(mk(1, 0, 0,            32'h0C, 1, mw(2),  32'h0C, 0));
    tbl.push_back(mk(0, 0, 0,            32'h10, 1, mw(3),  32'h10, 0));
    tbl.push_back(mk(1, 1, 32'h3E,       32'h3C, 0, 32'h0,  32'h10, 0));
    tbl.push_back(mk(0, 0, 0,            32'h40, 1, mw(15), 32'h40, 0));
    tbl.push_back(mk(0, 1, 32'h7D,       32'h7C, 0, 32'h0,  32'h40, 0));
    tbl.push_back(mk(0, 0, 0,            32'h80, 1, mw(31), 32'h80, 0));
    tbl.push_back(mk(0, 0, 0,            32'h80, 0, 32'h0,  32'h80, 1));
    tbl.push_back(mk(0, 0, 0,            32'h80, 0, 32'h0,  32'h80, 1));
    tbl.push_back(mk(1, 0, 0,            32'h80, 0, 32'h0,  32'h80, 1));
    tbl.push_back(mk(0, 1, 32'h00,       32'h00, 0, 32'h0,  32'h80, 0));
    tbl.push_back(mk(0, 0, 0,            32'h04, 1, mw(0),  32'h04, 0));
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 32'h0, 32'h04, 0));
    tbl.push_back(mk(0, 0, 0,            32'hFFFF_FFFC, 0, 32'h0, 32'h04, 1));

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Asynchronous reset while halted, mid-cycle, no clock edge in between.
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst", rst_exp);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(0, 0, 0, 32'h00, 0, 32'h0, 32'h00, 0), 100);
    step(mk(0, 0, 0, 32'h04, 1, mw(0), 32'h04, 0), 101);
    step(mk(0, 0, 0, 32'h08, 1, mw(1), 32'h08, 0), 102);

    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
